// File: rtl/jpeg_fifo_pkg.sv
// Shared definitions for the JPEG encoder output FIFO: default geometry,
// the address-width helper and the status bundle read by the FF byte-stuffing
// checker.
package jpeg_fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // Address bits needed to index a memory of the given depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Status bundle, packed so it can travel as a single bus.
  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic aempty;
    logic ovf;
    logic unf;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: one write port and one registered read port.
// Written so synthesis can map the array onto block RAM.
module fifo_mem_2p
  import jpeg_fifo_pkg::*;
#(
  parameter int  DATA_W = DEFAULT_DATA_W,
  parameter int  DEPTH  = DEFAULT_DEPTH,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  // NOTE: the array has no reset branch so it stays RAM-mappable; only the
  // output register below is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  // Registered read port: holds its value unless a read is accepted.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO between the Huffman/bit-packing stage and the
// FF byte-stuffing checker. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter; level and all flags are
// derived from registered pointers only, so no input reaches an output
// combinationally.
module sync_fifo_param
  import jpeg_fifo_pkg::*;
#(
  parameter int  DATA_W    = DEFAULT_DATA_W,
  parameter int  DEPTH     = DEFAULT_DEPTH,
  parameter int  AFULL_TH  = DEPTH - 2,
  parameter int  AEMPTY_TH = 2,
  localparam int AW        = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_req,
  output logic [DATA_W-1:0] read_data,
  output logic              rdata_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              underflow
);

  // Reject illegal geometry and thresholds at elaboration.
  if (DATA_W < 1) begin : g_chk_data_w
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_param: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
    $error("sync_fifo_param: AEMPTY_TH must be in 0..DEPTH-1");
  end

  localparam logic [AW:0] AFULL_LV  = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LV = (AW + 1)'(AEMPTY_TH);

  logic [AW:0]  write_ptr;
  logic [AW:0]  read_ptr;
  logic [AW:0]  fill;
  logic         wr_acc;
  logic         rd_acc;
  fifo_status_t status;

  // Occupancy and flags, all decoded from the registered pointers.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    status        = '0;
    fill          = write_ptr - read_ptr;
    status.empty  = (write_ptr == read_ptr);
    status.full   = (write_ptr[AW] != read_ptr[AW]) &&
                    (write_ptr[AW-1:0] == read_ptr[AW-1:0]);
    status.afull  = (fill >= AFULL_LV);
    status.aempty = (fill <= AEMPTY_LV);
    status.ovf    = overflow;
    status.unf    = underflow;
  end

  // A full FIFO refuses writes even when a read frees a slot this cycle, and
  // an empty one refuses reads even when a write arrives (no fall-through).
  assign wr_acc = write_enable & ~status.full;
  assign rd_acc = read_req & ~status.empty;

  assign fifo_empty   = status.empty;
  assign fifo_full    = status.full;
  assign almost_full  = status.afull;
  assign almost_empty = status.aempty;
  assign level        = fill;

  // Pointer advance, sticky error capture and read strobe; flush wins over
  // any request presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_ptr   <= '0;
      read_ptr    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      rdata_valid <= 1'b0;
    end else if (flush) begin
      write_ptr   <= '0;
      read_ptr    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      if (wr_acc) write_ptr <= write_ptr + 1'b1;
      if (rd_acc) read_ptr  <= read_ptr + 1'b1;
      if (write_enable && status.full) overflow  <= 1'b1;
      if (read_req && status.empty)    underflow <= 1'b1;
      rdata_valid <= rd_acc;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_acc & ~flush),
    .waddr (write_ptr[AW-1:0]),
    .wdata (write_data),
    .rd_en (rd_acc & ~flush),
    .raddr (read_ptr[AW-1:0]),
    .rdata (read_data)
  );

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO for the JPEG encoder output path. It buffers encoded words between the Huffman/bit-packing stage and the FF byte-stuffing checker, replacing the fixed 32-bit × 16 FIFO. Width and depth are configurable. It adds full, almost-full/almost-empty flags, a fill level, a synchronous flush, and sticky overflow/underflow error flags. Read data keeps the registered one-cycle read with a `rdata_valid` strobe.

## Interface
Parameters:
- `DATA_W`, 32, data word width in bits (≥1).
- `DEPTH`, 16, number of entries; power of two, ≥4.
- `AFULL_TH`, DEPTH-2, `almost_full` asserts when level ≥ this value (1..DEPTH).
- `AEMPTY_TH`, 2, `almost_empty` asserts when level ≤ this value (0..DEPTH-1).

Ports (AW = clog2(DEPTH)):
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset. Deasserts synchronously to `clk`, which is handled externally.
- `flush` in 1: synchronous clear of pointers, level and error flags.
- `write_enable` in 1: write request.
- `write_data` in DATA_W: write word.
- `read_req` in 1: read request.
- `read_data` out DATA_W: registered read word.
- `rdata_valid` out 1: `read_data` holds a newly popped word this cycle.
- `fifo_empty` out 1: level == 0.
- `fifo_full` out 1: level == DEPTH.
- `almost_full` out 1: level ≥ AFULL_TH.
- `almost_empty` out 1: level ≤ AEMPTY_TH.
- `level` out AW+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Pointers are AW+1 bits: `write_ptr` and `read_ptr`. Address = low AW bits. The MSB differing with equal low bits means full. Wrap is modulo 2^(AW+1).
- `wr_acc = write_enable & ~fifo_full`. `rd_acc = read_req & ~fifo_empty`. Both are evaluated on registered flags of the current cycle.
- Full plus simultaneous read: the read is accepted and the write is rejected, and `overflow` sets. Writes are never accepted into a full FIFO, even if a read occurs in the same cycle.
- Empty plus simultaneous write: the write is accepted and the read is rejected, and `underflow` sets. There is no fall-through.
- Level update per cycle: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither.
- Memory writes `mem[waddr] <= write_data` on wr_acc. `read_data <= mem[raddr]` on rd_acc. Otherwise `read_data` holds its value.
- `rdata_valid` is the registered version of rd_acc.
- Flush has priority over everything in the cycle it is asserted:
  - Pointers and level go to 0.
  - `overflow`, `underflow` and `rdata_valid` go to 0.
  - `read_data` holds its value and memory contents are untouched.
  - Any write or read presented in the flush cycle is discarded, and no error flag is set for it.
- Error flags are cleared only by reset or flush.
- Reset values: `read_data` 0, `rdata_valid` 0, `fifo_empty` 1, `fifo_full` 0, `almost_full` 0 (or 1 if AFULL_TH==0, which is illegal), `almost_empty` 1, `level` 0, `overflow` 0, `underflow` 0. Memory is not reset.
- Asserting reset mid-operation drops all contents immediately, with no clock required.

## Timing
- Write-to-read visibility: a word written at edge N sets `fifo_empty`=0 after edge N. A read request in cycle N+1 gives `read_data` and `rdata_valid`=1 after edge N+2.
- Read latency is one cycle from the accepted `read_req` edge to `read_data`/`rdata_valid`.
- Throughput is one write and one read per cycle sustained.
- All status outputs (`fifo_empty`, `fifo_full`, almost flags, `level`) are registered or derived only from registered pointers. There is no combinational path from inputs to outputs.
- Back-to-back reads deliver consecutive words, with `rdata_valid` high on each following cycle.

## Structure
- Package `jpeg_fifo_pkg`:
  - default `DATA_W`/`DEPTH` constants;
  - an `addr_w(depth)` function wrapping clog2;
  - a status struct typedef `fifo_status_t {empty, full, afull, aempty, ovf, unf}` for use by the stuffing checker.
- One sub-module, `fifo_mem_2p`: a simple dual-port array, with one write port and one registered read port, parametrised by DATA_W/DEPTH and mappable to block RAM. All pointer, flag and error logic stays in the top.
- Parameter legality (power-of-two DEPTH, threshold ranges) is checked by elaboration-time assertions.

## Test plan
- Reset then fill: DATA_W=32, DEPTH=16. Write 0x0000_0000..0x0000_000F in 16 cycles. Expected: level=16, `fifo_full`=1, `almost_full` from level 14, `overflow`=0.
- Overflow: on the full FIFO, write 0xDEAD_BEEF. Expected: level stays 16, `overflow`=1 and sticky. Draining 16 words returns 0x0..0xF in order, each with `rdata_valid`=1 one cycle after its request.
- Underflow/simultaneous: on an empty FIFO, write 0xFFFF_FF00 and read in the same cycle. Expected: write accepted, level=1, `underflow`=1, no `rdata_valid`. The next read returns 0xFFFF_FF00.
- Steady state and wrap: keep level at 8 with simultaneous read and write for 40 cycles, with incrementing data. Expected: level constant at 8, output sequence lags input by 8 words, pointers wrap with no glitch on `fifo_full`/`fifo_empty`.
- Flush priority: with level=5 and `overflow`=1, assert `flush` together with `write_enable` and `read_req`. Expected next cycle: level=0, `fifo_empty`=1, `overflow`=0, `rdata_valid`=0, and the write is discarded.
- Async reset mid-burst: drop `rst_n` between clock edges during a burst. Expected: outputs take reset values immediately. After release, the first written word 0x1234_5678 is the first read word.
